// File: rtl/cell3_pkg.sv
// Shared types and constants for the 3-input cell exerciser.
package cell3_pkg;

    // Exerciser sequencing states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FIN
    } state_t;

    // Expected-output tables indexed by {C,B,A}
    localparam logic [7:0] TRUTH_NOR3  = 8'h01;
    localparam logic [7:0] TRUTH_NAND3 = 8'h7F;
    localparam logic [7:0] TRUTH_AND3  = 8'h80;
    localparam logic [7:0] TRUTH_OR3   = 8'hFE;

    // Input vector index {C,B,A}
    localparam int VEC_W = 3;
    typedef logic [VEC_W-1:0] vec_t;

endpackage

// File: rtl/cell3_exerciser_if.sv
// Run-control and cell-side signals of the exerciser, bundled.
// master = exerciser side, slave = harness / cell side.
interface cell3_exerciser_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [7:0]       fail_vec;
    logic             a;
    logic             b;
    logic             c;
    logic             y;

    modport master (
        input  start, abort, y,
        output a, b, c, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        output start, abort, y,
        input  a, b, c, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/cell3_settle_timer.sv
// Load/decrement counter that holds a vector for SETTLE cycles.
// tc is high while the count is zero; loading SETTLE-1 therefore
// yields exactly SETTLE cycles of en before tc is seen.
module cell3_settle_timer
    import cell3_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt;

    // Reload on a new vector, otherwise count down to zero and hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/cell3_exerciser.sv
// Stimulus driver and response checker for 3-input static cells.
// Walks {C,B,A} = 0..7 for PASSES sweeps, holds each vector SETTLE
// cycles, then compares Y with TRUTH and records mismatches.
module cell3_exerciser
    import cell3_pkg::*;
#(
    parameter logic [7:0] TRUTH  = TRUTH_NOR3,
    parameter int         SETTLE = 4,
    parameter int         PASSES = 1,
    parameter int         ERR_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    cell3_exerciser_if.master   bus
);
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

    state_t           state, state_n;
    vec_t             vec, vec_n;
    logic [PW-1:0]    pidx, pidx_n;
    logic [ERR_W-1:0] err_q, err_n;
    logic [7:0]       fail_q, fail_n;
    logic             pass_q, pass_n;
    logic             busy_q, busy_n;
    logic [2:0]       abc_q, abc_n;
    logic             load;
    logic             settle_en;
    logic             tc;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

    assign settle_en = (state == ST_SETTLE);

    cell3_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .en    (settle_en),
        .tc    (tc)
    );

    // State, counters, results and the registered cell inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            vec    <= '0;
            pidx   <= '0;
            err_q  <= '0;
            fail_q <= '0;
            pass_q <= 1'b0;
            busy_q <= 1'b0;
            abc_q  <= '0;
        end else begin
            state  <= state_n;
            vec    <= vec_n;
            pidx   <= pidx_n;
            err_q  <= err_n;
            fail_q <= fail_n;
            pass_q <= pass_n;
            busy_q <= busy_n;
            abc_q  <= abc_n;
        end
    end

    // Sequencing, sampling and abort handling
    always_comb begin
        state_n = state;
        vec_n   = vec;
        pidx_n  = pidx;
        err_n   = err_q;
        fail_n  = fail_q;
        pass_n  = pass_q;
        busy_n  = busy_q;
        load    = 1'b0;

        case (state)
            ST_IDLE: begin
                // START beats a simultaneous ABORT because ABORT is a no-op here
                if (bus.start) begin
                    vec_n   = '0;
                    pidx_n  = '0;
                    err_n   = '0;
                    fail_n  = '0;
                    pass_n  = 1'b0;
                    busy_n  = 1'b1;
                    load    = 1'b1;
                    state_n = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tc) begin
                    state_n = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (bus.y != TRUTH[vec]) begin
                    fail_n[vec] = 1'b1;
                    err_n       = sat_inc(err_q);
                end
                if (vec == vec_t'(7)) begin
                    if (pidx == LAST_PASS) begin
                        state_n = ST_FIN;
                    end else begin
                        vec_n   = '0;
                        pidx_n  = pidx + PW'(1);
                        load    = 1'b1;
                        state_n = ST_SETTLE;
                    end
                end else begin
                    vec_n   = vec + vec_t'(1);
                    load    = 1'b1;
                    state_n = ST_SETTLE;
                end
            end
            ST_FIN: begin
                // err_q already includes the final sample, so zero means a clean run
                pass_n  = (err_q == '0);
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Abort drops any sample in flight and keeps the partial results
        if (bus.abort && (state != ST_IDLE)) begin
            state_n = ST_IDLE;
            vec_n   = '0;
            pidx_n  = '0;
            err_n   = err_q;
            fail_n  = fail_q;
            pass_n  = pass_q;
            busy_n  = 1'b0;
            load    = 1'b0;
        end
    end

    // Cell inputs follow the vector while a vector is being applied, else 0
    always_comb begin
        abc_n = '0;
        if ((state_n == ST_SETTLE) || (state_n == ST_SAMPLE)) begin
            abc_n = vec_n;
        end
    end

    assign bus.a        = abc_q[0];
    assign bus.b        = abc_q[1];
    assign bus.c        = abc_q[2];
    assign bus.busy     = busy_q;
    assign bus.done     = (state == ST_FIN);
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_cell3_exerciser.sv
// Bench for cell3_exerciser: three instances with different SETTLE/PASSES,
// a NOR3 cell model with selectable delay or stuck output, a cycle-count
// reference model and a per-cycle compare process.
module tb_cell3_exerciser;
    import cell3_pkg::*;

    localparam logic [7:0] TB_TRUTH = 8'h01;
    localparam int SS [3] = '{4, 4, 6};
    localparam int PP [3] = '{1, 3, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] st = '0;
    logic [2:0] ab = '0;
    logic [2:0] yv = 3'b111;
    logic [2:0] bz, dn, ps;
    logic [2:0] abc_o [3];
    logic [3:0] ec [3];
    logic [7:0] fv [3];

    int mode [3] = '{0, 0, 0};   // 0 = NOR3 with delay, 1 = stuck-0, 2 = stuck-1
    int dly  [3] = '{0, 0, 0};
    logic [2:0] hist [3][8];

    int n_chk = 0;
    int n_fail = 0;

    cell3_exerciser_if #(.ERR_W(4)) if0 ();
    cell3_exerciser_if #(.ERR_W(4)) if1 ();
    cell3_exerciser_if #(.ERR_W(4)) if2 ();

    assign if0.start = st[0]; assign if0.abort = ab[0]; assign if0.y = yv[0];
    assign if1.start = st[1]; assign if1.abort = ab[1]; assign if1.y = yv[1];
    assign if2.start = st[2]; assign if2.abort = ab[2]; assign if2.y = yv[2];

    assign bz[0] = if0.busy; assign dn[0] = if0.done; assign ps[0] = if0.pass;
    assign bz[1] = if1.busy; assign dn[1] = if1.done; assign ps[1] = if1.pass;
    assign bz[2] = if2.busy; assign dn[2] = if2.done; assign ps[2] = if2.pass;
    assign abc_o[0] = {if0.c, if0.b, if0.a};
    assign abc_o[1] = {if1.c, if1.b, if1.a};
    assign abc_o[2] = {if2.c, if2.b, if2.a};
    assign ec[0] = if0.err_cnt; assign fv[0] = if0.fail_vec;
    assign ec[1] = if1.err_cnt; assign fv[1] = if1.fail_vec;
    assign ec[2] = if2.err_cnt; assign fv[2] = if2.fail_vec;

    cell3_exerciser #(.TRUTH(8'h01), .SETTLE(4), .PASSES(1), .ERR_W(4))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    cell3_exerciser #(.TRUTH(8'h01), .SETTLE(4), .PASSES(3), .ERR_W(4))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    cell3_exerciser #(.TRUTH(8'h01), .SETTLE(6), .PASSES(1), .ERR_W(4))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Cell model: NOR3 of the inputs seen dly cycles ago, or a stuck output
    initial begin
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 8; k++) hist[i][k] = 3'd0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = abc_o[i];
                case (mode[i])
                    1:       yv[i] = 1'b0;
                    2:       yv[i] = 1'b1;
                    default: yv[i] = ~(|hist[i][dly[i]]);
                endcase
            end
        end
    end

    // Reference model: a run is a count of cycles since acceptance
    bit       m_run  [3];
    int       m_n    [3];
    bit [3:0] m_err  [3];
    bit [7:0] m_fail [3];
    bit       m_pass [3];

    initial begin
        int v;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    m_run[i] = 0; m_n[i] = 0; m_err[i] = 0; m_fail[i] = 0; m_pass[i] = 0;
                end else if (!m_run[i]) begin
                    if (st[i]) begin
                        m_run[i] = 1; m_n[i] = 1; m_err[i] = 0; m_fail[i] = 0; m_pass[i] = 0;
                    end
                end else if (ab[i]) begin
                    m_run[i] = 0;
                end else if (m_n[i] == 8 * PP[i] * (SS[i] + 1) + 1) begin
                    m_pass[i] = (m_err[i] == 0);
                    m_run[i] = 0;
                end else begin
                    if (m_n[i] % (SS[i] + 1) == 0) begin
                        v = ((m_n[i] - 1) / (SS[i] + 1)) % 8;
                        if (yv[i] != TB_TRUTH[v]) begin
                            m_fail[i][v] = 1'b1;
                            if (m_err[i] != 4'hF) m_err[i] = m_err[i] + 4'd1;
                        end
                    end
                    m_n[i]++;
                end
            end
        end
    end

    // Compare every instance against the model after every edge
    initial begin
        int t;
        logic e_busy, e_done;
        logic [2:0] e_abc;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                t = 8 * PP[i] * (SS[i] + 1);
                e_busy = m_run[i];
                e_done = m_run[i] && (m_n[i] == t + 1);
                e_abc  = (m_run[i] && m_n[i] <= t) ? 3'(((m_n[i] - 1) / (SS[i] + 1)) % 8) : 3'd0;
                chk($sformatf("dut%0d_outputs", i),
                    {14'd0, bz[i], dn[i], ps[i], abc_o[i], ec[i], fv[i]},
                    {14'd0, e_busy, e_done, m_pass[i], e_abc, m_err[i], m_fail[i]});
            end
        end
    end

    // Pulse START, optionally re-pulse START at cycle rp or ABORT at cycle abt,
    // and report the cycle DONE was seen (0 if never within bound)
    task automatic run(input int i, input int rp, input int abt, input int bound, output int cdone);
        int cyc;
        @(negedge clk); st[i] = 1'b1;
        @(negedge clk); cyc = 1; st[i] = (rp == 1); ab[i] = (abt == 1);
        while (!dn[i] && cyc < bound) begin
            @(negedge clk);
            cyc++;
            st[i] = (cyc == rp);
            ab[i] = (cyc == abt);
        end
        st[i] = 1'b0;
        ab[i] = 1'b0;
        cdone = dn[i] ? cyc : 0;
        if (dn[i]) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int c, cnt, i, t, rp, abt;

        repeat (3) @(negedge clk);
        chk("reset_state", {bz[0], dn[0], ps[0], abc_o[0], ec[0], fv[0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean NOR3
        mode[0] = 0; dly[0] = 0;
        run(0, 0, 0, 200, c);
        chk("nor3_done_cycle", c, 41);
        chk("nor3_pass", ps[0], 1);
        chk("nor3_err", ec[0], 0);
        chk("nor3_failvec", fv[0], 8'h00);

        // Stuck-0
        mode[0] = 1;
        run(0, 0, 0, 200, c);
        chk("stuck0_done_cycle", c, 41);
        chk("stuck0_failvec", fv[0], 8'h01);
        chk("stuck0_err", ec[0], 1);
        chk("stuck0_pass", ps[0], 0);

        // Stuck-1
        mode[0] = 2;
        run(0, 0, 0, 200, c);
        chk("stuck1_failvec", fv[0], 8'hFE);
        chk("stuck1_err", ec[0], 7);
        chk("stuck1_pass", ps[0], 0);

        // Three passes stuck-1: 21 mismatches saturate at 15
        mode[1] = 2;
        run(1, 0, 0, 300, c);
        chk("sat_done_cycle", c, 121);
        chk("sat_err", ec[1], 15);
        chk("sat_failvec", fv[1], 8'hFE);
        chk("sat_pass", ps[1], 0);

        // Slow cell: 5-cycle delay fails with SETTLE=4, passes with SETTLE=6
        mode[0] = 0; dly[0] = 5;
        run(0, 0, 0, 200, c);
        chk("slow_settle4_pass", ps[0], 0);
        chk("slow_settle4_failvec_nonzero", (fv[0] != 8'h00), 1);
        mode[2] = 0; dly[2] = 5;
        run(2, 0, 0, 200, c);
        chk("slow_settle6_done_cycle", c, 57);
        chk("slow_settle6_pass", ps[2], 1);
        chk("slow_settle6_failvec", fv[2], 8'h00);

        // START re-pulsed mid-run is ignored
        dly[0] = 0;
        run(0, 10, 0, 200, c);
        chk("restart_done_cycle", c, 41);
        cnt = 0;
        repeat (45) begin @(negedge clk); if (dn[0]) cnt++; end
        chk("restart_no_second_done", cnt, 0);

        // ABORT at cycle 12 with stuck-1: vectors 0 and 1 sampled
        mode[0] = 2;
        run(0, 0, 12, 60, c);
        chk("abort_no_done", c, 0);
        chk("abort_busy", bz[0], 0);
        chk("abort_abc", abc_o[0], 3'd0);
        chk("abort_failvec", fv[0], 8'h02);
        chk("abort_err", ec[0], 1);
        chk("abort_pass", ps[0], 0);

        // Reset at cycle 20 of a failing run, then a clean run
        @(negedge clk); st[0] = 1'b1;
        @(negedge clk); st[0] = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_reset_err", ec[0], 2);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", {bz[0], dn[0], ps[0], abc_o[0], ec[0], fv[0]}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        mode[0] = 0;
        run(0, 0, 0, 200, c);
        chk("post_reset_done_cycle", c, 41);
        chk("post_reset_pass", ps[0], 1);

        // Randomised runs: cell behaviour, re-pulses and aborts
        for (int it = 0; it < 24; it++) begin
            i = (it % 3 == 2) ? 2 : 0;
            mode[i] = $urandom_range(0, 2);
            dly[i]  = $urandom_range(0, 6);
            t = 8 * PP[i] * (SS[i] + 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            abt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, t + 4) : 0;
            rp  = (abt == 0) ? $urandom_range(2, t) : 0;
            run(i, rp, abt, 200, c);
            if (abt != 0 && abt < t + 1) chk($sformatf("rand%0d_aborted_no_done", it), c, 0);
            else chk($sformatf("rand%0d_done_cycle", it), c, t + 1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
